// File: rtl/axi_rd_arbiter.sv
// Two-master AXI-lite read arbiter: one read in flight, AR/R forwarded combinationally to/from the owner.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default build gives m1 (LSU) fixed priority.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e state_q;
  logic   ar_done_q;
  logic   last_grant_q;
  logic   tie_to_m1;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_to_m1 = ~last_grant_q;
`else
  // LSU always wins ties; last_grant_q is still tracked so both builds share one state machine.
  assign tie_to_m1 = 1'b1 | last_grant_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ar_done_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (m0_arvalid && m1_arvalid) begin
            state_q <= tie_to_m1 ? GRANT1 : GRANT0;
          end else if (m0_arvalid) begin
            state_q <= GRANT0;
          end else if (m1_arvalid) begin
            state_q <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          // s_arvalid needs ~ar_done and s_rready needs ar_done, so at most one of these fires.
          if (s_arvalid && s_arready) begin
            ar_done_q <= 1'b1;
          end
          if (s_rvalid && s_rready) begin
            state_q      <= IDLE;
            ar_done_q    <= 1'b0;
            last_grant_q <= (state_q == GRANT1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    grant      = '0;
    unique case (state_q)
      GRANT0: begin
        grant      = 2'b01;
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid & ~ar_done_q;
        m0_arready = s_arready & ~ar_done_q;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready & ar_done_q;
      end
      GRANT1: begin
        grant      = 2'b10;
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid & ~ar_done_q;
        m1_arready = s_arready & ~ar_done_q;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready & ar_done_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: vector table, directed corner sequences, randomized traffic vs. a transaction model.
module tb_axi_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] KEY = 32'h5A5A_0F0F;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [1:0] TIE_FIRST = RR ? 2'b01 : 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
  logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]    m0_rresp, m1_rresp, s_rresp;
  logic          m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant(grant)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] cur_addr [2];
  int          masters_left;
  bit          r_done_flag;

  typedef struct {
    logic        m0v, m1v, sar;
    logic [1:0]  eg;
    logic        esv, e0r, e1r;
    logic [31:0] ea;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic get_arready(input int id);
    return (id == 0) ? m0_arready : m1_arready;
  endfunction
  function automatic logic get_rvalid(input int id);
    return (id == 0) ? m0_rvalid : m1_rvalid;
  endfunction
  function automatic logic get_rready(input int id);
    return (id == 0) ? m0_rready : m1_rready;
  endfunction
  function automatic logic [31:0] get_rdata(input int id);
    return (id == 0) ? m0_rdata : m1_rdata;
  endfunction
  function automatic logic [1:0] get_rresp(input int id);
    return (id == 0) ? m0_rresp : m1_rresp;
  endfunction

  task automatic set_ar(input int id, input logic v, input logic [31:0] a);
    if (id == 0) begin m0_arvalid = v; m0_araddr = a; end
    else begin m1_arvalid = v; m1_araddr = a; end
  endtask
  task automatic set_rready(input int id, input logic v);
    if (id == 0) m0_rready = v; else m1_rready = v;
  endtask

  task automatic clear_inputs();
    m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b0;
    m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
  endtask

  // Leaves the caller at a negedge with reset released and all inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Zero-wait memory: waits for a grant, performs AR then R, returns at the negedge of the following idle cycle.
  task automatic serve(input logic [31:0] data, input logic [1:0] resp,
                       output logic [1:0] g, output logic [31:0] a,
                       output logic [31:0] d, output logic [1:0] r, output int idle);
    g = '0; a = '0; d = '0; r = '0; idle = 0;
    s_arready = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (grant != 2'b00) begin g = grant; a = s_araddr; break; end
      idle++;
      @(negedge clk);
    end
    if (g == 2'b00) return;
    @(negedge clk);
    if (g == 2'b01) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = data; s_rresp = resp;
    #1;
    d = (g == 2'b01) ? m0_rdata : m1_rdata;
    r = (g == 2'b01) ? m0_rresp : m1_rresp;
    @(negedge clk);
    s_rvalid = 1'b0;
  endtask

  task automatic master_run(input int id, input int n);
    logic [31:0] addr;
    bit          done;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      addr = ($urandom() & 32'h7FFF_FFFF) | ((id == 1) ? 32'h8000_0000 : 32'h0);
      cur_addr[id] = addr;
      set_ar(id, 1'b1, addr);
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
        #1;
        if (get_arready(id)) done = 1'b1;
        @(negedge clk);
      end
      chk("rand_ar_handshake", 32'(done), 32'd1);
      set_ar(id, 1'b0, addr);
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
        set_rready(id, $urandom_range(0, 3) != 0);
        #1;
        if (get_rvalid(id) && get_rready(id)) begin
          chk("rand_rdata", get_rdata(id), addr ^ KEY);
          chk("rand_rresp", 32'(get_rresp(id)), 32'(addr[3:2]));
          r_done_flag = 1'b1;
          done = 1'b1;
        end
        @(negedge clk);
      end
      chk("rand_r_handshake", 32'(done), 32'd1);
      set_rready(id, 1'b0);
    end
    masters_left--;
  endtask

  task automatic mem_run();
    bit          busy = 1'b0;
    bit          was_busy;
    int          delay = 0;
    logic [31:0] addr = '0;
    while (masters_left > 0) begin
      s_arready = ($urandom_range(0, 2) != 0);
      if (busy && delay == 0) begin
        s_rvalid = 1'b1; s_rdata = addr ^ KEY; s_rresp = addr[3:2];
      end else begin
        s_rvalid = 1'b0;
      end
      #1;
      was_busy = busy;
      if (s_rvalid && s_rready) busy = 1'b0;
      else if (busy && delay > 0) delay--;
      if (s_arvalid && s_arready) begin
        chk("rand_no_dup_ar", 32'(was_busy), 32'd0);
        chk("rand_ar_addr", s_araddr, cur_addr[s_araddr[31]]);
        busy = 1'b1; addr = s_araddr; delay = $urandom_range(0, 4);
      end
      @(negedge clk);
    end
    s_arready = 1'b0; s_rvalid = 1'b0;
  endtask

  // Owner model: who should hold the port each cycle, derived from request and completion events only.
  task automatic mon_run();
    logic [1:0] mg = 2'b00;
    bit         mlast = 1'b1;
    while (masters_left > 0) begin
      #2;
      chk("rand_grant", 32'(grant), 32'(mg));
      if (mg != 2'b01) chk("rand_m0_quiet", 32'({m0_arready, m0_rvalid}), 32'd0);
      if (mg != 2'b10) chk("rand_m1_quiet", 32'({m1_arready, m1_rvalid}), 32'd0);
      if (mg == 2'b00) begin
        if (m0_arvalid && m1_arvalid) mg = RR ? (mlast ? 2'b01 : 2'b10) : 2'b10;
        else if (m0_arvalid) mg = 2'b01;
        else if (m1_arvalid) mg = 2'b10;
      end else if (r_done_flag) begin
        mlast = (mg == 2'b10);
        mg = 2'b00;
        r_done_flag = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [1:0]  g, g2, r;
    logic [31:0] a, a2, d;
    int          idle, hs;
    logic [1:0]  exp_ties [4];

    rst = 1'b1;
    clear_inputs();

    vecs[0] = '{m0v:1'b0, m1v:1'b0, sar:1'b1, eg:2'b00, esv:1'b0, e0r:1'b0, e1r:1'b0, ea:32'h0};
    vecs[1] = '{m0v:1'b1, m1v:1'b0, sar:1'b0, eg:2'b01, esv:1'b1, e0r:1'b0, e1r:1'b0, ea:32'hA0};
    vecs[2] = '{m0v:1'b1, m1v:1'b0, sar:1'b1, eg:2'b01, esv:1'b1, e0r:1'b1, e1r:1'b0, ea:32'hA0};
    vecs[3] = '{m0v:1'b0, m1v:1'b1, sar:1'b1, eg:2'b10, esv:1'b1, e0r:1'b0, e1r:1'b1, ea:32'hB0};
    vecs[4] = '{m0v:1'b1, m1v:1'b1, sar:1'b1, eg:TIE_FIRST, esv:1'b1,
                e0r:(TIE_FIRST == 2'b01), e1r:(TIE_FIRST == 2'b10), ea:(RR ? 32'hA0 : 32'hB0)};

    #1;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_s_arvalid", 32'(s_arvalid), 32'd0);
    chk("reset_s_rready", 32'(s_rready), 32'd0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      m0_araddr = 32'hA0; m1_araddr = 32'hB0;
      m0_arvalid = vecs[i].m0v; m1_arvalid = vecs[i].m1v;
      @(negedge clk);
      s_arready = vecs[i].sar;
      #1;
      chk("vec_grant", 32'(grant), 32'(vecs[i].eg));
      chk("vec_s_arvalid", 32'(s_arvalid), 32'(vecs[i].esv));
      chk("vec_m0_arready", 32'(m0_arready), 32'(vecs[i].e0r));
      chk("vec_m1_arready", 32'(m1_arready), 32'(vecs[i].e1r));
      chk("vec_s_araddr", s_araddr, vecs[i].ea);
    end

    // Single m0 read: arbitrate, AR, R.
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000;
    #1;
    chk("single_idle_grant", 32'(grant), 32'd0);
    chk("single_idle_arvalid", 32'(s_arvalid), 32'd0);
    @(negedge clk);
    s_arready = 1'b1;
    #1;
    chk("single_grant", 32'(grant), 32'b01);
    chk("single_s_arvalid", 32'(s_arvalid), 32'd1);
    chk("single_s_araddr", s_araddr, 32'h8000_0000);
    chk("single_m0_arready", 32'(m0_arready), 32'd1);
    @(negedge clk);
    m0_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678; s_rresp = 2'd0; m0_rready = 1'b1;
    #1;
    chk("single_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("single_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("single_s_rready", 32'(s_rready), 32'd1);
    chk("single_m1_rvalid", 32'(m1_rvalid), 32'd0);
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    chk("single_back_idle", 32'(grant), 32'd0);

    // Simultaneous 0x100 / 0x200 requests.
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h100;
    m1_arvalid = 1'b1; m1_araddr = 32'h200;
    serve(32'h1, 2'd0, g, a, d, r, idle);
    serve(32'h2, 2'd0, g2, a2, d, r, idle);
    chk("tie_first_grant", 32'(g), RR ? 32'b01 : 32'b10);
    chk("tie_first_addr", a, RR ? 32'h100 : 32'h200);
    chk("tie_second_grant", 32'(g2), RR ? 32'b10 : 32'b01);
    chk("tie_second_addr", a2, RR ? 32'h200 : 32'h100);
    chk("tie_dead_cycle", 32'(idle), 32'd1);

    // Four repeated ties.
    for (int i = 0; i < 4; i++) exp_ties[i] = RR ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b10;
    do_reset();
    m0_araddr = 32'h10; m1_araddr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      m0_arvalid = 1'b1; m1_arvalid = 1'b1;
      serve(32'h0, 2'd0, g, a, d, r, idle);
      chk("ties_grant", 32'(g), 32'(exp_ties[i]));
      chk("ties_idle", 32'(idle), 32'd1);
    end
    clear_inputs();

    // AR stall 3 cycles, R delay, m1 rready low for 2 cycles.
    do_reset();
    hs = 0;
    m1_arvalid = 1'b1; m1_araddr = 32'h3000_0040;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      s_rvalid = (i == 1); m1_rready = (i == 1);
      #1;
      hs += int'(s_arvalid && s_arready);
      chk("stall_s_arvalid", 32'(s_arvalid), 32'd1);
      chk("stall_m1_arready", 32'(m1_arready), 32'd0);
      chk("stall_early_rready", 32'(s_rready), 32'd0);
      @(negedge clk);
    end
    s_rvalid = 1'b0; m1_rready = 1'b0; s_arready = 1'b1;
    #1;
    hs += int'(s_arvalid && s_arready);
    chk("stall_ar_accept", 32'(m1_arready), 32'd1);
    chk("stall_addr", s_araddr, 32'h3000_0040);
    @(negedge clk);
    m1_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      hs += int'(s_arvalid && s_arready);
      chk("stall_rwait_grant", 32'(grant), 32'b10);
      @(negedge clk);
    end
    s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      #1;
      hs += int'(s_arvalid && s_arready);
      chk("stall_rready_low", 32'(s_rready), 32'd0);
      chk("stall_m1_rvalid", 32'(m1_rvalid), 32'd1);
      @(negedge clk);
    end
    m1_rready = 1'b1;
    #1;
    hs += int'(s_arvalid && s_arready);
    chk("stall_rready_high", 32'(s_rready), 32'd1);
    chk("stall_m1_rdata", m1_rdata, 32'hCAFE_F00D);
    chk("stall_one_ar", 32'(hs), 32'd1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("stall_back_idle", 32'(grant), 32'd0);
    @(negedge clk);

    // Error response on m1.
    do_reset();
    m1_arvalid = 1'b1; m1_araddr = 32'h44;
    serve(32'hDEAD_BEEF, 2'd2, g, a, d, r, idle);
    chk("err_grant", 32'(g), 32'b10);
    chk("err_rresp", 32'(r), 32'd2);
    chk("err_rdata", d, 32'hDEAD_BEEF);
    #1;
    chk("err_back_idle", 32'(grant), 32'd0);

    // Reset in GRANT1 after the AR handshake.
    do_reset();
    m1_arvalid = 1'b1; m1_araddr = 32'h60; s_arready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_ar", 32'(s_arvalid), 32'd1);
    @(negedge clk);
    m1_arvalid = 1'b0; s_arready = 1'b0;
    rst = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h7777_7777; m1_rready = 1'b1;
    #1;
    chk("rst_mid_grant", 32'(grant), 32'd0);
    chk("rst_mid_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_mid_m1_rdata", m1_rdata, 32'd0);
    chk("rst_mid_s_rready", 32'(s_rready), 32'd0);
    @(negedge clk);
    rst = 1'b0; s_rvalid = 1'b0; m1_rready = 1'b0;
    m0_arvalid = 1'b1; m0_araddr = 32'h70;
    serve(32'h0, 2'd0, g, a, d, r, idle);
    chk("rst_after_grant", 32'(g), 32'b01);
    chk("rst_after_addr", a, 32'h70);
    chk("rst_after_latency", 32'(idle), 32'd1);

    // Randomized concurrent traffic.
    do_reset();
    masters_left = 2;
    r_done_flag = 1'b0;
    fork
      master_run(0, 40);
      master_run(1, 40);
      mem_run();
      mon_run();
    join
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-requester arbiter sharing the single AXI-lite read port of data memory between the instruction fetch unit (master 0) and the load/store unit (master 1). It accepts one read transaction at a time, forwards the granted master's AR channel to the memory side, steers the R response back to that master only, and returns to idle after the R handshake. It sits between the IFU/LSU read channels and the memory read port. Write channels do not pass through this block.

## Interface
- ADDR_W, 32, address width of every araddr
- DATA_W, 32, data width of every rdata
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- m{0,1}_araddr  in  ADDR_W  read address from master i
- m{0,1}_arvalid  in  1  read request from master i, held until its arready
- m{0,1}_arready  out  1  AR accept to master i
- m{0,1}_rdata  out  DATA_W  read data to master i
- m{0,1}_rresp  out  2  read response to master i
- m{0,1}_rvalid  out  1  read data valid to master i
- m{0,1}_rready  in  1  master i ready for R
- s_araddr  out  ADDR_W  address to memory
- s_arvalid  out  1  request to memory
- s_arready  in  1  memory accepts AR
- s_rdata  in  DATA_W  memory read data
- s_rresp  in  2  memory response
- s_rvalid  in  1  memory data valid
- s_rready  out  1  R accept to memory
- grant  out  2  one-hot current owner, 00 in IDLE

## Operation
- States: IDLE, GRANT0, GRANT1. Registers: state, ar_done, last_grant.
- IDLE: all outputs to masters and memory are 0. Requests are sampled: only m0_arvalid -> GRANT0; only m1_arvalid -> GRANT1; both -> priority rule (Configuration); none -> stay.
- GRANTi: s_araddr = mi_araddr; s_arvalid = mi_arvalid & ~ar_done; mi_arready = s_arready & ~ar_done. On s_arvalid & s_arready, ar_done <= 1.
- R path in GRANTi: mi_rdata/mi_rresp/mi_rvalid = s_rdata/s_rresp/s_rvalid; s_rready = mi_rready & ar_done. On s_rvalid & s_rready: state <= IDLE, ar_done <= 0, last_grant <= i.
- Non-granted master: arready, rvalid, rdata, rresp all 0; its request is held by the master and arbitrated on next IDLE.
- rresp is forwarded unmodified; any rresp value, including nonzero, ends the transaction.
- s_rvalid before ar_done (protocol violation) is ignored: s_rready stays 0.
- Reset (any cycle, including mid-transaction): state=IDLE, ar_done=0, last_grant=1, grant=00; all outputs 0 combinationally from reset state. An in-flight memory response is dropped; memory is reset by the same rst.

## Timing
- Grant latency: arvalid seen in IDLE at cycle N -> s_arvalid=1 at N+1.
- AR and R paths are combinational through the block inside GRANTi; no extra pipeline stage.
- Completion handshake cycle N -> IDLE at N+1 -> earliest next s_arvalid at N+2. One dead cycle between back-to-back grants.
- Minimum transaction with zero-wait memory: 3 cycles (arbitrate, AR, R).

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the master not in last_grant (reset value 1 => m0 wins first tie).
- Undefined: fixed priority, m1 (LSU) always wins ties; last_grant still maintained but unused.

## Test plan
- Single m0 read: m0_araddr=0x8000_0000, memory returns 0x1234_5678 rresp=0 -> m0 sees rdata 0x1234_5678, s_arvalid at cycle N+1, grant=01, m1_rvalid never 1.
- Simultaneous requests, fixed priority: m0 0x100, m1 0x200 together -> memory sees 0x200 first then 0x100; grant 10 then 01 with one IDLE cycle between.
- Simultaneous, ARB_ROUND_ROBIN_EN, 4 repeated ties -> grant order 01,10,01,10.
- Memory AR stall 3 cycles and R delay 5 cycles with m1 rready=0 for 2 extra cycles -> s_arvalid held, one AR handshake only, s_rready follows m1_rready, no duplicate AR.
- Error response rresp=2 on m1 read -> forwarded as m1_rresp=2, arbiter returns to IDLE.
- rst asserted in GRANT1 after AR handshake -> outputs 0 immediately, grant=00; next m0 request granted normally after release.
